// File: rtl/conv_tile_streamer.sv
// conv_tile_streamer: unpacks a 45-byte kernel+tile frame, kicks the convolution engine
// and streams its 16 results; flags framing errors and engine timeouts.
module conv_tile_streamer #(
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic [7:0]  kernel [0:2][0:2],
  output logic [7:0]  input_tile [0:5][0:5],
  output logic        start,
  input  logic [15:0] c [0:3][0:3],
  input  logic        done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err_frame,
  output logic        err_timeout
);
  localparam int WW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {LOAD_K, LOAD_T, START, WAIT, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          done_prev_q;
  logic          err_frame_q, err_frame_d;
  logic          err_timeout_q, err_timeout_d;
  logic [7:0]    k_q [9], k_d [9];
  logic [7:0]    t_q [36], t_d [36];
  logic [15:0]   res_q [16], res_d [16];
  logic          hs, bad_last, done_rise;
  genvar i, j;
  assign s_ready     = state_q == LOAD_K || state_q == LOAD_T;
  assign hs          = s_valid && s_ready;
  // s_last must coincide exactly with the 36th tile byte
  assign bad_last    = s_last != (state_q == LOAD_T && cnt_q == 6'd35);
  assign done_rise   = done && !done_prev_q;
  assign start       = state_q == START;
  assign busy        = state_q != LOAD_K;
  assign m_valid     = state_q == DRAIN;
  assign m_data      = m_valid ? res_q[idx_q] : '0;
  assign m_last      = m_valid && idx_q == 4'd15;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  for (i = 0; i < 3; i++) begin : g_kr
    for (j = 0; j < 3; j++) begin : g_kc
      assign kernel[i][j] = k_q[3*i+j];
    end
  end
  for (i = 0; i < 6; i++) begin : g_tr
    for (j = 0; j < 6; j++) begin : g_tc
      assign input_tile[i][j] = t_q[6*i+j];
    end
  end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    k_d           = k_q;
    t_d           = t_q;
    res_d         = res_q;
    case (state_q)
      LOAD_K: if (hs) begin
        for (int n = 0; n < 9; n++) if (cnt_q == 6'(n)) k_d[n] = s_data;
        if (bad_last) begin
          err_frame_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == 6'd8) begin
          state_d = LOAD_T;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      LOAD_T: if (hs) begin
        for (int n = 0; n < 36; n++) if (cnt_q == 6'(n)) t_d[n] = s_data;
        if (bad_last) begin
          err_frame_d = 1'b1;
          state_d     = LOAD_K;
          cnt_d       = '0;
        end else if (cnt_q == 6'd35) begin
          state_d = START;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
      START: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      // a done edge takes priority over a timeout landing on the same cycle
      WAIT: if (done_rise) begin
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) res_d[4*a+b] = c[a][b];
        idx_d   = '0;
        state_d = DRAIN;
      end else if (wcnt_q == WW'(DONE_TIMEOUT - 1)) begin
        state_d       = LOAD_K;
        err_timeout_d = 1'b1;
      end else wcnt_d = wcnt_q + WW'(1);
      DRAIN: if (m_ready) begin
        if (idx_q == 4'd15) begin
          state_d = LOAD_K;
          idx_d   = '0;
        end else idx_d = idx_q + 4'd1;
      end
      default: state_d = LOAD_K;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD_K;
      cnt_q         <= '0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      done_prev_q   <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      k_q           <= '{default: '0};
      t_q           <= '{default: '0};
      res_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      done_prev_q   <= done;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      k_q           <= k_d;
      t_q           <= t_d;
      res_q         <= res_d;
    end
  end
endmodule

// File: tb/tb_conv_tile_streamer.sv
// tb_conv_tile_streamer: frame-level reference model plus a programmable engine model;
// scenario table, reset-in-drain sequence and randomized frames.
module tb_conv_tile_streamer;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic [7:0]  kernel [0:2][0:2];
  logic [7:0]  input_tile [0:5][0:5];
  logic        start, done;
  logic [15:0] c [0:3][0:3];
  logic        m_valid, m_ready, m_last, busy, err_frame, err_timeout;
  logic [15:0] m_data;

  conv_tile_streamer #(.DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .kernel(kernel), .input_tile(input_tile), .start(start), .c(c),
    .done(done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  typedef struct {
    int          bad_at;
    int          fall_at;
    int          rise_at;
    int          mr_mode;
    logic [15:0] base;
    int          words;
    bit          ef;
    bit          et;
  } vec_t;
  vec_t vecs [12];

  int total = 0, bad = 0;
  bit          loading, start_due, ef_due, et_due, dprev, hs_seen;
  int          pos, wait_left;
  logic [15:0] exp_q [$];
  logic [7:0]  mk [9];
  logic [7:0]  mt [36];
  int          ecyc, fall_at, rise_at, mr_mode;
  logic [15:0] cbase;
  int          n_words, n_ef, n_et, n_start;

  task automatic chk1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_arrays();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) chk16("kernel", 16'(kernel[i][j]), 16'(mk[3*i+j]));
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) chk16("tile", 16'(input_tile[i][j]), 16'(mt[6*i+j]));
  endtask

  task automatic model_reset();
    loading = 1; start_due = 0; ef_due = 0; et_due = 0; dprev = 0;
    pos = 0; wait_left = 0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) mk[i] = '0;
    for (int i = 0; i < 36; i++) mt[i] = '0;
  endtask

  // one clock cycle: drive engine/sink inputs, check outputs, advance the model
  task automatic step();
    m_ready = mr_mode == 0 ? 1'b1 : mr_mode == 1 ? !m_ready : 1'($urandom_range(0, 1));
    if (ecyc >= 0) begin
      ecyc++;
      if (ecyc == fall_at) done = 1'b0;
      if (ecyc == rise_at) done = 1'b1;
    end
    hs_seen = 0;
    chk1("s_ready", s_ready, loading);
    chk1("busy", busy, !(loading && pos < 9));
    chk1("start", start, start_due);
    chk1("m_valid", m_valid, exp_q.size() != 0);
    chk1("err_frame", err_frame, ef_due);
    chk1("err_timeout", err_timeout, et_due);
    if (exp_q.size() != 0) begin
      chk16("m_data", m_data, exp_q[0]);
      chk1("m_last", m_last, exp_q.size() == 1);
    end
    if (start) begin
      n_start++;
      ecyc = 0;
      chk_arrays();
    end
    if (err_frame) n_ef++;
    if (err_timeout) n_et++;
    if (m_valid && m_ready) n_words++;
    ef_due = 0;
    et_due = 0;
    if (loading) begin
      if (s_valid) begin
        hs_seen = 1;
        if (pos < 9) mk[pos] = s_data; else mt[pos-9] = s_data;
        if (s_last != (pos == 44)) begin
          ef_due = 1;
          pos = 0;
        end else if (pos == 44) begin
          loading = 0;
          start_due = 1;
          pos = 0;
        end else pos++;
      end
    end else if (start_due) begin
      start_due = 0;
      wait_left = TO;
    end else if (wait_left > 0) begin
      if (done && !dprev) begin
        wait_left = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(cbase + 16'(16 * (k / 4) + k % 4));
      end else begin
        wait_left--;
        if (wait_left == 0) begin
          et_due = 1;
          loading = 1;
        end
      end
    end else if (exp_q.size() != 0 && m_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) loading = 1;
    end
    dprev = done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done = 1'b0;
    ecyc = -1;
    s_valid = 1'b0;
    #1;
    model_reset();
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_start", start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err_frame", err_frame, 1'b0);
    chk1("rst_err_timeout", err_timeout, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chk16("rst_m_data", m_data, 16'h0);
    chk_arrays();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(int bad_at, bit rnd);
    for (int k = 1; k <= 45; k++) begin
      int g = 0;
      s_data = rnd ? 8'($urandom) : (k <= 9 ? 8'(k) : 8'(k - 10));
      s_last = bad_at == 0 ? k == 45 : bad_at == 45 ? 1'b0 : k == bad_at;
      hs_seen = 0;
      while (!hs_seen && g < 100) begin
        s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        step();
        g++;
      end
      chk1("byte_accepted", hs_seen, 1'b1);
      if (bad_at != 0 && k == bad_at) break;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain_idle();
    int g = 0;
    while (!(loading && exp_q.size() == 0 && !ef_due && !et_due && !start_due) && g < 400) begin
      step();
      g++;
    end
    chk1("idle_reached", g < 400, 1'b1);
    repeat (2) step();
  endtask

  task automatic setup_vec(vec_t v);
    cbase = v.base;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c[i][j] = v.base + 16'(16 * i + j);
    fall_at = v.fall_at;
    rise_at = v.rise_at;
    mr_mode = v.mr_mode;
    ecyc = -1;
    n_words = 0; n_ef = 0; n_et = 0; n_start = 0;
  endtask

  task automatic run_vec(vec_t v, bit rnd);
    setup_vec(v);
    send_frame(v.bad_at, rnd);
    drain_idle();
    chk_int("words", n_words, v.words);
    chk_int("err_frame_cnt", n_ef, int'(v.ef));
    chk_int("timeout_cnt", n_et, int'(v.et));
    chk_int("starts", n_start, v.bad_at == 0 ? 1 : 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    //            bad fall rise mr base      words ef    et
    vecs[0]  = '{0,  1, 5,  0, 16'h0000, 16, 1'b0, 1'b0};
    vecs[1]  = '{0,  1, 5,  1, 16'h0000, 16, 1'b0, 1'b0};
    vecs[2]  = '{20, 1, 5,  0, 16'h0000, 0,  1'b1, 1'b0};
    vecs[3]  = '{0,  1, 5,  0, 16'h0100, 16, 1'b0, 1'b0};
    vecs[4]  = '{45, 1, 5,  0, 16'h0000, 0,  1'b1, 1'b0};
    vecs[5]  = '{0,  1, 0,  0, 16'h0000, 0,  1'b0, 1'b1};
    vecs[6]  = '{0,  1, 16, 0, 16'h0200, 16, 1'b0, 1'b0};
    vecs[7]  = '{0,  1, 17, 0, 16'h0000, 0,  1'b0, 1'b1};
    vecs[8]  = '{0,  0, 0,  0, 16'h0000, 0,  1'b0, 1'b1};
    vecs[9]  = '{0,  3, 6,  0, 16'h0300, 16, 1'b0, 1'b0};
    vecs[10] = '{1,  1, 5,  0, 16'h0000, 0,  1'b1, 1'b0};
    vecs[11] = '{0,  1, 5,  1, 16'hABC0, 16, 1'b0, 1'b0};
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; done = 1'b0;
    mr_mode = 0; fall_at = 0; rise_at = 0; ecyc = -1; cbase = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c[i][j] = '0;
    rst_n = 1'b1;
    #2;
    do_reset();
    for (int v = 0; v < 12; v++) run_vec(vecs[v], 1'b0);
    // reset while draining: progress lost, next frame complete
    begin
      int g = 0;
      setup_vec(vecs[0]);
      send_frame(0, 1'b0);
      while (n_words < 5 && g < 200) begin
        step();
        g++;
      end
      chk_int("words_before_reset", n_words, 5);
      do_reset();
      run_vec(vecs[0], 1'b0);
    end
    for (int f = 0; f < 16; f++) begin
      vec_t v;
      v.bad_at  = $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 45)) : 0;
      v.fall_at = 1;
      v.rise_at = int'($urandom_range(2, 18));
      v.mr_mode = 2;
      v.base    = 16'($urandom);
      v.words   = (v.bad_at == 0 && v.rise_at <= TO) ? 16 : 0;
      v.ef      = v.bad_at != 0;
      v.et      = v.bad_at == 0 && v.rise_at > TO;
      run_vec(v, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_tile_streamer.md
CONV_TILE_STREAMER -- requirements
Module: conv_tile_streamer

Interface
REQ-001 Parameter: DONE_TIMEOUT, 1024, maximum cycles spent in WAIT before abandoning the frame (>=2).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  inbound byte valid.
REQ-005 s_ready  output  1  inbound byte accepted when s_valid & s_ready.
REQ-006 s_data  input  8  inbound byte (unsigned).
REQ-007 s_last  input  1  marks final byte of a frame.
REQ-008 kernel  output  8 x [0:2][0:2]  kernel drive to convolution engine.
REQ-009 input_tile  output  8 x [0:5][0:5]  tile drive to convolution engine.
REQ-010 start  output  1  one-cycle start pulse to engine.
REQ-011 c  input  16 x [0:3][0:3]  engine result array.
REQ-012 done  input  1  engine completion (level; may remain high).
REQ-013 m_valid  output  1  outbound result valid.
REQ-014 m_ready  input  1  outbound result accepted when m_valid & m_ready.
REQ-015 m_data  output  16  outbound result word.
REQ-016 m_last  output  1  high with 16th result word of a frame.
REQ-017 busy  output  1  high whenever state != LOAD_K.
REQ-018 err_frame  output  1  one-cycle pulse on framing error.
REQ-019 err_timeout  output  1  one-cycle pulse on engine timeout.

Function
REQ-020 States: LOAD_K, LOAD_T, START, WAIT, DRAIN; one byte counter (0..35), one result index (0..15), one wait counter.
REQ-021 Frame = 45 bytes: 9 kernel bytes row-major kernel[0][0]..kernel[2][2], then 36 tile bytes row-major input_tile[0][0]..input_tile[5][5].
REQ-022 s_ready = 1 only in LOAD_K and LOAD_T; each accepted byte is written to its slot on the accepting edge; counter advances only on a handshake.
REQ-023 LOAD_K -> LOAD_T after 9th byte; LOAD_T -> START after 36th tile byte.
REQ-024 s_last must be 1 on byte 45 only; s_last on any earlier byte, or s_last=0 on byte 45: byte still written, err_frame pulses the following cycle, counters clear, state -> LOAD_K, start is not issued.
REQ-025 START lasts exactly one cycle with start=1; next state WAIT; start=0 in all other states.
REQ-026 done is detected on rising edge only (done=1 while previous-cycle done=0), sampled only in WAIT; a level left high from an earlier frame never completes a frame.
REQ-027 On done edge in WAIT: all 16 c values captured into an internal result buffer on that edge; state -> DRAIN; m_valid=1 the next cycle.
REQ-028 Wait counter clears on entering WAIT, increments each WAIT cycle; reaching DONE_TIMEOUT without done edge: err_timeout pulses one cycle, state -> LOAD_K, no output words.
REQ-029 Done edge and timeout in same cycle: done edge wins.
REQ-030 DRAIN: m_valid=1, m_data = buffer[index], order c[0][0],c[0][1]..c[3][3]; m_last=1 only at index 15; index advances on handshake.
REQ-031 m_data, m_last stable while m_valid=1 and m_ready=0.
REQ-032 After 16th handshake: m_valid=0 next cycle, state -> LOAD_K, byte counter 0; new frame bytes may be accepted from that cycle.
REQ-033 kernel/input_tile hold last written values outside LOAD_K/LOAD_T (not cleared between frames).
REQ-034 Minimum latency: last byte accepted at edge T -> start=1 cycle T+1; done edge sampled at edge D -> first m_valid cycle D+1.

Reset
REQ-035 rst_n=0 immediately: state LOAD_K, all counters 0, kernel, input_tile, result buffer all 0; start, m_valid, m_last, err_frame, err_timeout, busy = 0; m_data = 0; s_ready=1 once rst_n deasserted.
REQ-036 Reset mid-frame, mid-WAIT or mid-DRAIN discards all progress; no further start or m_valid until a complete new frame.

Verification
REQ-037 Kernel bytes 1..9, tile bytes 0..35, s_last on byte 45, model engine returns c[i][j]=16*i+j via done edge 5 cycles after start -> single start pulse; 16 words 0x0000..0x0033 in row-major order, m_last with 0x0033.
REQ-038 Same frame with m_ready toggling 1-0 every cycle -> m_data held during stalls, 16 words exactly, no duplicates or drops.
REQ-039 s_last on byte 20 -> err_frame one cycle, no start, next 45-byte frame processed normally.
REQ-040 Engine never asserts done, DONE_TIMEOUT=16 -> err_timeout exactly 16 cycles after WAIT entry, state LOAD_K, m_valid never 1.
REQ-041 done held high from prior frame into next WAIT -> no completion until done falls and rises again; else timeout.
REQ-042 rst_n pulsed low during DRAIN after 5 words -> m_valid=0 immediately, all outputs at reset values, fresh frame yields full 16 words.
